build_phrase: RTL and testbench
===============================

// Module: build_phrase
// PURPOSE
//  Packs a stream of 16-bit pixel words into 128-bit phrases for the frame-buffer write path;
//  mirror stage of digest_phrase, sitting between the camera pixel stream and the memory write FIFO.
//  Frame-start flag on a word becomes phrase_tuser on the phrase containing that word.
//  A frame start landing mid-phrase flushes the partial phrase zero-padded, so every frame begins phrase-aligned.
// PARAMETERS
//  WORD_WIDTH        16   bits per input word
//  WORDS_PER_PHRASE  8    words per output phrase; phrase width = WORD_WIDTH*WORDS_PER_PHRASE (128)
// PORTS
//  clk_in         in   1    single clock, all logic on rising edge
//  rst_in         in   1    synchronous reset, ACTIVE-LOW (0 = reset)
//  valid_word     in   1    input word valid
//  ready_word     out  1    input word accepted when valid_word && ready_word
//  word           in   16   input pixel word
//  newframe_in    in   1    qualifies word: first word of a new frame
//  valid_phrase   out  1    output phrase valid
//  ready_phrase   in   1    output phrase consumed when valid_phrase && ready_phrase
//  phrase_data    out  128  packed phrase; word k of phrase in bits [16k+15:16k], k=0 accepted first
//  phrase_tuser   out  1    phrase begins a new frame
//  flush_count    out  16   number of zero-padded (partial) phrases emitted since reset, wraps at 2^16
// BEHAVIOUR
//  - Storage: accumulator (7 words + count 0..7 + pending-tuser bit) and one output register (phrase, tuser, valid).
//  - Reset (rst_in==0 at edge): count=0, pending tuser=0, valid_phrase=0, phrase_data=0, phrase_tuser=0,
//    flush_count=0; ready_word reads 1 in reset-released idle. Reset mid-phrase discards partial words, no flush.
//  - Output register free this cycle: out_free = !valid_phrase || ready_phrase.
//  - Normal accept (newframe_in=0 or count==0): word written to slot count.
//      count<7: count++ ; if count==0 && newframe_in, pending tuser<=1.
//      count==7: phrase = {word, acc[6:0]} loaded into output register with tuser=pending; count<=0, pending<=0.
//      Latency: 8th word accepted at edge N -> valid_phrase=1 after edge N (same edge loads register).
//  - Mid-phrase frame start (valid_word && newframe_in && count!=0): partial phrase acc[count-1:0], upper
//    slots zero, loaded to output with tuser=pending; flush_count++; the new word becomes slot 0, count<=1,
//    pending<=1. All in one accepting edge.
//  - ready_word = out_free when (count==7) or (newframe_in && count!=0); else 1. Combinational from
//    valid_phrase, ready_phrase, count, newframe_in; never from valid_word.
//  - Output hold: while valid_phrase && !ready_phrase, phrase_data/phrase_tuser stable; valid_phrase only
//    drops on a handshake with no simultaneous reload. Back-to-back: handshake and reload on same edge -> valid stays 1.
//  - valid_word low: no state change except output drain. Words never dropped, never duplicated.
//  - newframe_in with count==0 is a normal accept (no flush, no empty phrase ever emitted).
//  - WORDS_PER_PHRASE=1 degenerate case not supported; must be >=2.
// TESTING
//  1. Reset, ready_phrase=1, feed words 0x0001..0x0008 (newframe on first) -> one phrase
//     128'h0008_0007_0006_0005_0004_0003_0002_0001, tuser=1, valid 1 cycle after 8th accept.
//  2. Continuous 16 words, ready_phrase=1 -> two phrases on consecutive-capable edges, ready_word never low,
//     second phrase tuser=0.
//  3. ready_phrase=0 holding a full phrase, feed 8 more -> 7 accepted, ready_word=0 on 8th, phrase_data stable;
//     raise ready_phrase -> 8th accepted same cycle, new phrase loaded, valid_phrase stays 1.
//  4. Feed 0xAAAA,0xBBBB,0xCCCC then 0xDDDD with newframe_in -> phrase 128'h0000_..._CCCC_BBBB_AAAA with
//     tuser=prior pending, flush_count=1; next 7 words complete a phrase with slot0=0xDDDD, tuser=1.
//  5. Mid-phrase newframe while output full and ready_phrase=0 -> ready_word=0, no state change until drain.
//  6. Assert rst_in=0 with count=5 and valid_phrase=1 -> all outputs at reset values next edge; subsequent
//     8 words form a clean phrase with no leftover data.

Source files
------------

// File: rtl/build_phrase_if.sv
// Word-in / phrase-out handshake bundle for build_phrase.
// The master side feeds pixel words and consumes phrases; the slave side is the packer.
interface build_phrase_if #(
  parameter int WORD_WIDTH       = 16,
  parameter int WORDS_PER_PHRASE = 8
);
  localparam int PHRASE_WIDTH = WORD_WIDTH * WORDS_PER_PHRASE;

  logic                    valid_word;
  logic                    ready_word;
  logic [WORD_WIDTH-1:0]   word;
  logic                    newframe_in;
  logic                    valid_phrase;
  logic                    ready_phrase;
  logic [PHRASE_WIDTH-1:0] phrase_data;
  logic                    phrase_tuser;
  logic [15:0]             flush_count;

  modport master (
    output valid_word, word, newframe_in, ready_phrase,
    input  ready_word, valid_phrase, phrase_data, phrase_tuser, flush_count
  );

  modport slave (
    input  valid_word, word, newframe_in, ready_phrase,
    output ready_word, valid_phrase, phrase_data, phrase_tuser, flush_count
  );
endinterface

// File: rtl/build_phrase.sv
// Packs 16-bit pixel words into 128-bit phrases; a frame start landing mid-phrase
// flushes the partial phrase zero-padded so every frame begins phrase-aligned.
module build_phrase #(
  parameter int WORD_WIDTH       = 16,
  parameter int WORDS_PER_PHRASE = 8
) (
  input logic           clk_in,
  input logic           rst_in,
  build_phrase_if.slave bus
);
  localparam int PW = WORD_WIDTH * WORDS_PER_PHRASE;
  localparam int CW = $clog2(WORDS_PER_PHRASE);
  localparam logic [CW-1:0] LAST = CW'(WORDS_PER_PHRASE - 1);

  logic [CW-1:0] count_reg;
  logic          pending_reg;
  logic          valid_reg;
  logic          tuser_reg;
  logic [PW-1:0] phrase_reg;
  logic [15:0]   flush_reg;

  logic          out_free;
  logic          is_last;
  logic          mid_flush;
  logic          accept;
  logic          load;
  logic [PW-1:0] phrase_next;

  assign out_free       = !valid_reg || bus.ready_phrase;
  assign is_last        = (count_reg == LAST);
  assign mid_flush      = bus.newframe_in && (count_reg != '0);
  assign bus.ready_word = (is_last || mid_flush) ? out_free : 1'b1;
  assign accept         = bus.valid_word && bus.ready_word;
  assign load           = accept && (is_last || mid_flush);

  // Slots at or above count hold stale words, so they are masked to zero on a flush.
  generate
    for (genvar gi = 0; gi < WORDS_PER_PHRASE - 1; gi++) begin : gen_slot
      logic [WORD_WIDTH-1:0] slot_reg;
      logic                  slot_we;

      assign slot_we = accept && (mid_flush ? (gi == 0)
                                            : (!is_last && (count_reg == CW'(gi))));
      assign phrase_next[gi*WORD_WIDTH +: WORD_WIDTH] =
          (CW'(gi) < count_reg) ? slot_reg : '0;

      always_ff @(posedge clk_in) begin
        if (!rst_in) begin
          slot_reg <= '0;
        end else if (slot_we) begin
          slot_reg <= bus.word;
        end
      end
    end
  endgenerate

  assign phrase_next[PW-1 -: WORD_WIDTH] = mid_flush ? '0 : bus.word;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      count_reg   <= '0;
      pending_reg <= 1'b0;
      valid_reg   <= 1'b0;
      tuser_reg   <= 1'b0;
      phrase_reg  <= '0;
      flush_reg   <= '0;
    end else begin
      if (load) begin
        phrase_reg <= phrase_next;
        tuser_reg  <= pending_reg;
        valid_reg  <= 1'b1;
      end else if (bus.ready_phrase) begin
        valid_reg  <= 1'b0;
      end

      if (accept) begin
        if (mid_flush) begin
          // The frame-start word opens the next phrase in the same edge.
          count_reg   <= CW'(1);
          pending_reg <= 1'b1;
          flush_reg   <= flush_reg + 16'd1;
        end else if (is_last) begin
          count_reg   <= '0;
          pending_reg <= 1'b0;
        end else begin
          count_reg <= count_reg + CW'(1);
          if ((count_reg == '0) && bus.newframe_in) begin
            pending_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.valid_phrase = valid_reg;
  assign bus.phrase_data  = phrase_reg;
  assign bus.phrase_tuser = tuser_reg;
  assign bus.flush_count  = flush_reg;
endmodule

// File: tb/tb_build_phrase.sv
// Bench for build_phrase: directed scenarios plus a random stream scored against
// a queue-based model of phrase packing and frame-start flushing.
module tb_build_phrase;
  localparam int WPP = 8;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  build_phrase_if #(.WORD_WIDTH(16), .WORDS_PER_PHRASE(WPP)) bus ();

  build_phrase #(.WORD_WIDTH(16), .WORDS_PER_PHRASE(WPP)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int total  = 0;
  int passed = 0;
  int stalls = 0;
  bit rand_rp = 1'b0;

  logic [15:0]  cur[$];
  logic         cur_tuser = 1'b0;
  logic [128:0] exp_q[$];
  logic [128:0] obs_q[$];
  int           exp_flush = 0;

  function automatic logic [128:0] pack_cur();
    logic [128:0] p = '0;
    foreach (cur[i]) p[i*16 +: 16] = cur[i];
    p[128] = cur_tuser;
    return p;
  endfunction

  function automatic void model_word(logic [15:0] w, logic nf);
    if (nf && cur.size() != 0) begin
      exp_q.push_back(pack_cur());
      exp_flush++;
      cur.delete();
    end
    if (cur.size() == 0) cur_tuser = nf;
    cur.push_back(w);
    if (cur.size() == WPP) begin
      exp_q.push_back(pack_cur());
      cur.delete();
    end
  endfunction

  always @(posedge clk_in) begin
    if (!rst_in) begin
      cur.delete();
      exp_q.delete();
      obs_q.delete();
      exp_flush = 0;
    end else begin
      if (bus.valid_phrase && bus.ready_phrase) begin
        obs_q.push_back({bus.phrase_tuser, bus.phrase_data});
        $display("phrase out tuser=%0b data=%h", bus.phrase_tuser, bus.phrase_data);
      end
      if (bus.valid_word && bus.ready_word) model_word(bus.word, bus.newframe_in);
    end
  end

  task automatic send(input logic [15:0] w, input logic nf);
    int n = 0;
    @(negedge clk_in);
    if (rand_rp) bus.ready_phrase = 1'($urandom_range(0, 1));
    bus.valid_word = 1'b1; bus.word = w; bus.newframe_in = nf;
    #1;
    while (!bus.ready_word && n < 500) begin
      stalls++;
      @(negedge clk_in);
      if (rand_rp) bus.ready_phrase = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    if (!bus.ready_word) begin
      total++;
      $display("FAIL send_timeout: ready_word=%0b required 1 for word %h", bus.ready_word, w);
    end
    @(posedge clk_in); #1;
    bus.valid_word = 1'b0; bus.newframe_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic test_reset();
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    total++; if (bus.valid_phrase !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.valid_phrase); else passed++;
    total++; if (bus.phrase_data !== 128'h0) $display("FAIL reset_data: got %h want 0", bus.phrase_data); else passed++;
    total++; if (bus.phrase_tuser !== 1'b0) $display("FAIL reset_tuser: got %0b want 0", bus.phrase_tuser); else passed++;
    total++; if (bus.flush_count !== 16'h0) $display("FAIL reset_flush: got %0d want 0", bus.flush_count); else passed++;
    @(negedge clk_in); rst_in = 1'b1; #1;
    total++; if (bus.ready_word !== 1'b1) $display("FAIL reset_ready: got %0b want 1", bus.ready_word); else passed++;
  endtask

  task automatic test_single_phrase();
    bus.ready_phrase = 1'b1;
    for (int i = 1; i <= 7; i++) send(16'(i), i == 1);
    total++; if (bus.valid_phrase !== 1'b0) $display("FAIL single_early_valid: got %0b want 0", bus.valid_phrase); else passed++;
    send(16'h0008, 1'b0);
    total++; if (bus.valid_phrase !== 1'b1) $display("FAIL single_valid: got %0b want 1", bus.valid_phrase); else passed++;
    total++; if (bus.phrase_data !== 128'h0008_0007_0006_0005_0004_0003_0002_0001)
      $display("FAIL single_data: got %h want 00080007000600050004000300020001", bus.phrase_data); else passed++;
    total++; if (bus.phrase_tuser !== 1'b1) $display("FAIL single_tuser: got %0b want 1", bus.phrase_tuser); else passed++;
    idle(2);
  endtask

  task automatic test_back_to_back();
    obs_q.delete(); exp_q.delete();
    bus.ready_phrase = 1'b1;
    stalls = 0;
    for (int i = 0; i < 16; i++) send(16'($urandom), 1'b0);
    idle(2);
    total++; if (stalls != 0) $display("FAIL b2b_stalls: got %0d want 0", stalls); else passed++;
    total++; if (obs_q.size() != 2) $display("FAIL b2b_count: got %0d want 2", obs_q.size()); else passed++;
    if (obs_q.size() == 2 && exp_q.size() == 2) begin
      total++; if (obs_q[1][128] !== 1'b0) $display("FAIL b2b_tuser: got %0b want 0", obs_q[1][128]); else passed++;
      for (int i = 0; i < 2; i++) begin
        total++; if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_phrase%0d: got %h want %h", i, obs_q[i], exp_q[i]); else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    @(negedge clk_in); bus.ready_phrase = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h0010 + 16'(i), i == 0);
    for (int i = 0; i < 7; i++) send(16'h0020 + 16'(i), 1'b0);
    @(negedge clk_in);
    bus.valid_word = 1'b1; bus.word = 16'h0027; bus.newframe_in = 1'b0; #1;
    held = bus.phrase_data;
    total++; if (bus.ready_word !== 1'b0) $display("FAIL bp_ready_low: got %0b want 0", bus.ready_word); else passed++;
    total++; if (held !== 128'h0017_0016_0015_0014_0013_0012_0011_0010)
      $display("FAIL bp_first: got %h want 00170016001500140013001200110010", held); else passed++;
    repeat (3) @(posedge clk_in); #1;
    total++; if (bus.phrase_data !== held) $display("FAIL bp_hold: got %h want %h", bus.phrase_data, held); else passed++;
    @(negedge clk_in); bus.ready_phrase = 1'b1; #1;
    total++; if (bus.ready_word !== 1'b1) $display("FAIL bp_ready_high: got %0b want 1", bus.ready_word); else passed++;
    @(posedge clk_in); #1;
    bus.valid_word = 1'b0;
    total++; if (bus.valid_phrase !== 1'b1) $display("FAIL bp_valid_stays: got %0b want 1", bus.valid_phrase); else passed++;
    total++; if (bus.phrase_data !== 128'h0027_0026_0025_0024_0023_0022_0021_0020)
      $display("FAIL bp_second: got %h want 00270026002500240023002200210020", bus.phrase_data); else passed++;
    idle(2);
  endtask

  task automatic test_midframe_flush();
    logic [15:0] fc0;
    bus.ready_phrase = 1'b1;
    fc0 = bus.flush_count;
    send(16'hAAAA, 1'b0); send(16'hBBBB, 1'b0); send(16'hCCCC, 1'b0);
    send(16'hDDDD, 1'b1);
    total++; if (bus.phrase_data !== 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA)
      $display("FAIL mid_data: got %h want 0000000000000000000000CCCCBBBBAAAA", bus.phrase_data); else passed++;
    total++; if (bus.phrase_tuser !== 1'b0) $display("FAIL mid_tuser: got %0b want 0", bus.phrase_tuser); else passed++;
    total++; if (bus.flush_count !== fc0 + 16'd1) $display("FAIL mid_flush: got %0d want %0d", bus.flush_count, fc0 + 16'd1); else passed++;
    for (int i = 1; i <= 7; i++) send(16'(i), 1'b0);
    total++; if (bus.phrase_data !== 128'h0007_0006_0005_0004_0003_0002_0001_DDDD)
      $display("FAIL mid_next_data: got %h want 000700060005000400030002 0001DDDD", bus.phrase_data); else passed++;
    total++; if (bus.phrase_tuser !== 1'b1) $display("FAIL mid_next_tuser: got %0b want 1", bus.phrase_tuser); else passed++;
    idle(2);
  endtask

  task automatic test_flush_blocked();
    logic [127:0] held;
    logic [15:0]  fc0;
    @(negedge clk_in); bus.ready_phrase = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h0030 + 16'(i), 1'b0);
    for (int i = 0; i < 3; i++) send(16'h0040 + 16'(i), 1'b0);
    @(negedge clk_in);
    bus.valid_word = 1'b1; bus.word = 16'h0050; bus.newframe_in = 1'b1; #1;
    held = bus.phrase_data;
    fc0  = bus.flush_count;
    total++; if (bus.ready_word !== 1'b0) $display("FAIL fb_ready_low: got %0b want 0", bus.ready_word); else passed++;
    repeat (3) @(posedge clk_in); #1;
    total++; if (bus.phrase_data !== held) $display("FAIL fb_hold: got %h want %h", bus.phrase_data, held); else passed++;
    total++; if (bus.flush_count !== fc0) $display("FAIL fb_flush_hold: got %0d want %0d", bus.flush_count, fc0); else passed++;
    @(negedge clk_in); bus.ready_phrase = 1'b1; #1;
    total++; if (bus.ready_word !== 1'b1) $display("FAIL fb_ready_high: got %0b want 1", bus.ready_word); else passed++;
    @(posedge clk_in); #1;
    bus.valid_word = 1'b0; bus.newframe_in = 1'b0;
    total++; if (bus.flush_count !== fc0 + 16'd1) $display("FAIL fb_flush: got %0d want %0d", bus.flush_count, fc0 + 16'd1); else passed++;
    total++; if (bus.phrase_data !== 128'h0000_0000_0000_0000_0000_0042_0041_0040)
      $display("FAIL fb_data: got %h want 0000000000000000000000420041 0040", bus.phrase_data); else passed++;
    for (int i = 1; i <= 7; i++) send(16'h0050 + 16'(i), 1'b0);
    total++; if (bus.phrase_data[15:0] !== 16'h0050 || bus.phrase_tuser !== 1'b1)
      $display("FAIL fb_next: got slot0=%h tuser=%0b want slot0=0050 tuser=1", bus.phrase_data[15:0], bus.phrase_tuser); else passed++;
    idle(2);
  endtask

  task automatic test_reset_midphrase();
    @(negedge clk_in); bus.ready_phrase = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h0060 + 16'(i), 1'b1 && i == 0);
    for (int i = 0; i < 5; i++) send(16'h0070 + 16'(i), 1'b0);
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    total++; if (bus.valid_phrase !== 1'b0) $display("FAIL rmid_valid: got %0b want 0", bus.valid_phrase); else passed++;
    total++; if (bus.phrase_data !== 128'h0) $display("FAIL rmid_data: got %h want 0", bus.phrase_data); else passed++;
    total++; if (bus.phrase_tuser !== 1'b0) $display("FAIL rmid_tuser: got %0b want 0", bus.phrase_tuser); else passed++;
    total++; if (bus.flush_count !== 16'h0) $display("FAIL rmid_flush: got %0d want 0", bus.flush_count); else passed++;
    @(negedge clk_in); rst_in = 1'b1; bus.ready_phrase = 1'b1; #1;
    total++; if (bus.ready_word !== 1'b1) $display("FAIL rmid_ready: got %0b want 1", bus.ready_word); else passed++;
    for (int i = 0; i < 8; i++) send(16'h0080 + 16'(i), 1'b0);
    total++; if (bus.phrase_data !== 128'h0087_0086_0085_0084_0083_0082_0081_0080 || bus.phrase_tuser !== 1'b0)
      $display("FAIL rmid_clean: got %h tuser=%0b want 00870086008500840083008200810080 tuser=0", bus.phrase_data, bus.phrase_tuser); else passed++;
    idle(2);
  endtask

  task automatic test_random();
    obs_q.delete(); exp_q.delete();
    rand_rp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(16'($urandom), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) idle(1);
    end
    rand_rp = 1'b0;
    @(negedge clk_in); bus.ready_phrase = 1'b1;
    idle(4);
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) $display("FAIL rand_phrase%0d: got %h want %h", i, obs_q[i], exp_q[i]); else passed++;
    end
    total++; if (bus.flush_count !== 16'(exp_flush)) $display("FAIL rand_flush: got %0d want %0d", bus.flush_count, exp_flush); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_word   = 1'b0;
    bus.word         = '0;
    bus.newframe_in  = 1'b0;
    bus.ready_phrase = 1'b1;
    repeat (3) @(posedge clk_in);
    test_reset();
    test_single_phrase();
    test_back_to_back();
    test_backpressure();
    test_midframe_flush();
    test_flush_blocked();
    test_reset_midphrase();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
